// File: rtl/mult_datapath.sv
// Register/arithmetic datapath (X, A, B, shift counter) for the signed shift-add multiplier.
// Optional HEX_DISPLAY_EN adds registered active-low 7-segment nibble outputs.
module mult_datapath #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned N_STEPS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr_Ld,
  input  logic              Add,
  input  logic              Sub,
  input  logic              Shift,
  input  logic [N_BITS-1:0] S,
  output logic              M,
  output logic              X,
  output logic [N_BITS-1:0] Aval,
  output logic [N_BITS-1:0] Bval,
  output logic [3:0]        ShiftCnt,
  output logic              Done,
  output logic              ProtoErr
`ifdef HEX_DISPLAY_EN
  ,
  output logic [6:0]        AhexU,
  output logic [6:0]        AhexL,
  output logic [6:0]        BhexU,
  output logic [6:0]        BhexL
`endif
);

  localparam int unsigned AW = N_BITS + 1;
  localparam int unsigned CW = 4;

  logic              r_x;
  logic [N_BITS-1:0] r_a;
  logic [N_BITS-1:0] r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic              r_err;

  logic              w_x_nxt;
  logic [N_BITS-1:0] w_a_nxt;
  logic [N_BITS-1:0] w_b_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_err_nxt;
  logic [AW-1:0]     w_sum;
  logic [AW-1:0]     w_diff;
  logic [2:0]        w_nstrobe;
  logic              w_multi;

  assign w_sum     = {r_a[N_BITS-1], r_a} + {S[N_BITS-1], S};
  assign w_diff    = {r_a[N_BITS-1], r_a} - {S[N_BITS-1], S};
  assign w_nstrobe = 3'(Clr_Ld) + 3'(Add) + 3'(Sub) + 3'(Shift);
  assign w_multi   = (w_nstrobe > 3'd1);

  // Strobe arbitration: Clr_Ld > Sub > Add > Shift; violations latch r_err.
  always_comb begin
    w_x_nxt   = r_x;
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    if (Clr_Ld) begin
      w_x_nxt   = 1'b0;
      w_a_nxt   = '0;
      w_b_nxt   = S;
      w_cnt_nxt = '0;
      w_err_nxt = 1'b0;
    end else begin
      if (w_multi) w_err_nxt = 1'b1;
      if (Sub) begin
        {w_x_nxt, w_a_nxt} = w_diff;
      end else if (Add) begin
        {w_x_nxt, w_a_nxt} = w_sum;
      end else if (Shift) begin
        if (r_done) begin
          w_err_nxt = 1'b1;
        end else begin
          w_a_nxt   = {r_x, r_a[N_BITS-1:1]};
          w_b_nxt   = {r_a[0], r_b[N_BITS-1:1]};
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x    <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_a    <= w_a_nxt;
      r_b    <= w_b_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= (w_cnt_nxt == CW'(N_STEPS));
      r_err  <= w_err_nxt;
    end
  end

  assign M        = r_b[0];
  assign X        = r_x;
  assign Aval     = r_a;
  assign Bval     = r_b;
  assign ShiftCnt = r_cnt;
  assign Done     = r_done;
  assign ProtoErr = r_err;

`ifdef HEX_DISPLAY_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [6:0] r_ahex_u, r_ahex_l, r_bhex_u, r_bhex_l;

  // Display follows the A/B registers one cycle later.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ahex_u <= 7'h40;
      r_ahex_l <= 7'h40;
      r_bhex_u <= 7'h40;
      r_bhex_l <= 7'h40;
    end else begin
      r_ahex_u <= seg7(r_a[7:4]);
      r_ahex_l <= seg7(r_a[3:0]);
      r_bhex_u <= seg7(r_b[7:4]);
      r_bhex_l <= seg7(r_b[3:0]);
    end
  end

  assign AhexU = r_ahex_u;
  assign AhexL = r_ahex_l;
  assign BhexU = r_bhex_u;
  assign BhexL = r_bhex_l;
`endif

endmodule
